uart_tx_fifo: RTL

//  Parametrised UART transmitter, successor to the fixed 8N1 TX. Adds configurable data width,

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_gen.sv | 42 ++++
 rtl/uart_tx_fifo.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Definitions shared by the UART TX and the future RX block:
//             parity mode codes and the frame state machine encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_gen
//  Purpose  : Fractional baud tick generator. A 32-bit phase accumulator
//             advances by BAUD every clock and wraps at CLK_HZ; each wrap
//             emits a one-cycle tick. Mean tick period is CLK_HZ/BAUD with
//             at most one cycle of jitter. Free-running after reset.
//  Ports    : clk   in  1  system clock
//             rst_n in  1  asynchronous active-low reset
//             tick  out 1  one-cycle pulse per bit period (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int CLK_HZ = 74000000,
    parameter int BAUD   = 115200
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [31:0] acc;
    logic [32:0] nxt;

    // One extra bit so the sum cannot wrap before the compare.
    assign nxt = {1'b0, acc} + 33'(BAUD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (nxt >= 33'(CLK_HZ)) begin
            acc  <= 32'(nxt - 33'(CLK_HZ));
            tick <= 1'b1;
        end else begin
            acc  <= nxt[31:0];
            tick <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Parametrised UART transmitter with TX FIFO. Configurable data
//             width, parity and stop bits; fractional baud generator.
//  Ports    : sys_clk_i      in  1          system clock
//             sys_rstn_i     in  1          asynchronous active-low reset
//             uart_wr_i      in  1          write strobe (ignored when full)
//             uart_dat_i     in  DATA_BITS  word to send, LSB first
//             uart_ovf_clr_i in  1          clears the overflow flag
//             uart_tx        out 1          serial line, idle high
//             uart_busy_o    out 1          frame in progress or FIFO not empty
//             uart_full_o    out 1          FIFO holds FIFO_DEPTH entries
//             uart_empty_o   out 1          FIFO holds no entries
//             uart_level_o   out AW+1       FIFO occupancy
//             uart_ovf_o     out 1          sticky: a write was dropped
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 74000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rstn_i,
    input  logic                          uart_wr_i,
    input  logic [DATA_BITS-1:0]          uart_dat_i,
    input  logic                          uart_ovf_clr_i,
    output logic                          uart_tx,
    output logic                          uart_busy_o,
    output logic                          uart_full_o,
    output logic                          uart_empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   uart_level_o,
    output logic                          uart_ovf_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
    end
    if (BAUD <= 0 || BAUD >= CLK_HZ / 4) begin : g_bad_baud
        $error("uart_tx_fifo: BAUD must be positive and below CLK_HZ/4");
    end

    // ------------------------------------------------------------------
    // Baud tick
    // ------------------------------------------------------------------
    logic tick;

    uart_baud_gen #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_baud_gen (
        .clk   (sys_clk_i),
        .rst_n (sys_rstn_i),
        .tick  (tick)
    );

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        level;
    logic [LW-1:0]        level_nxt;
    logic                 full;
    logic                 empty;
    logic                 ovf;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    assign push = uart_wr_i & ~full;
    assign head = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= uart_dat_i;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            full  <= (level_nxt == LW'(FIFO_DEPTH));
            empty <= (level_nxt == '0);
            // A dropped write outranks a clear in the same cycle.
            if (uart_wr_i && full) begin
                ovf <= 1'b1;
            end else if (uart_ovf_clr_i) begin
                ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [3:0]           bitcnt_q, bitcnt_d;
    logic [1:0]           stopcnt_q, stopcnt_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            stopcnt_q <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            stopcnt_q <= stopcnt_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        stopcnt_d = stopcnt_q;
        par_d     = par_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    tx_d = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_d = head;
                        par_d   = (PARITY == PARITY_ODD) ? ~(^head) : ^head;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    tx_d     = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = 4'd1;
                    state_d  = ST_DATA;
                end
                ST_DATA: begin
                    if (bitcnt_q < 4'(DATA_BITS)) begin
                        tx_d     = shreg_q[0];
                        shreg_d  = shreg_q >> 1;
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (PARITY != PARITY_NONE) begin
                        tx_d    = par_q;
                        state_d = ST_PARITY;
                    end else begin
                        tx_d      = 1'b1;
                        stopcnt_d = 2'd1;
                        state_d   = ST_STOP;
                    end
                end
                ST_PARITY: begin
                    tx_d      = 1'b1;
                    stopcnt_d = 2'd1;
                    state_d   = ST_STOP;
                end
                ST_STOP: begin
                    if (stopcnt_q < 2'(STOP_BITS)) begin
                        stopcnt_d = stopcnt_q + 2'd1;
                    end else if (!empty) begin
                        // Chain straight into the next start bit, no idle gap.
                        pop     = 1'b1;
                        shreg_d = head;
                        par_d   = (PARITY == PARITY_ODD) ? ~(^head) : ^head;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign uart_tx      = tx_q;
    assign uart_busy_o  = (state_q != ST_IDLE) | ~empty;
    assign uart_full_o  = full;
    assign uart_empty_o = empty;
    assign uart_level_o = level;
    assign uart_ovf_o   = ovf;

endmodule
`default_nettype wire
